// File: rtl/credit_debtor.sv
// Sending-side credit holder: gates a valid/ready stream on a non-zero credit balance
// and requests more credit from the downstream creditor when the balance runs low.
module credit_debtor #(
  parameter int WIDTH          = 16,
  parameter int CREDIT_WIDTH   = 8,
  parameter int COUNTER_WIDTH  = 10,
  parameter int INITIAL_CREDIT = 0,
  parameter int LOW_WATERMARK  = 4,
  parameter int RETRY_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     borrow,
  input  logic [CREDIT_WIDTH-1:0]  credit,
  input  logic                     credit_valid,
  output logic [COUNTER_WIDTH-1:0] balance,
  output logic                     error
);

  localparam int CW1     = COUNTER_WIDTH + 1;
  localparam int RETRY_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  localparam logic [COUNTER_WIDTH-1:0] INIT_BAL   = COUNTER_WIDTH'(INITIAL_CREDIT);
  localparam logic [CW1-1:0]           LOW_WM     = CW1'(LOW_WATERMARK);
  localparam logic [RETRY_W-1:0]       RETRY_LOAD = RETRY_W'(RETRY_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_balance;
  logic                     r_error;
  logic                     r_borrow;
  logic [RETRY_W-1:0]       r_retry;

  logic           w_nonzero;
  logic           w_xfer;
  logic           w_unsol;
  logic           w_ovf;
  logic [CW1-1:0] w_grant;
  logic [CW1-1:0] w_sum;

  assign w_nonzero = (r_balance != '0);
  assign out_valid = in_valid & w_nonzero;
  assign in_ready  = out_ready & w_nonzero;
  assign out_data  = in_data;
  assign w_xfer    = out_valid & out_ready;

  // One extra bit catches overflow; underflow is impossible since a transfer needs balance != 0.
  assign w_grant = credit_valid ? {{(CW1-CREDIT_WIDTH){1'b0}}, credit} : '0;
  assign w_sum   = {1'b0, r_balance} + w_grant - {{COUNTER_WIDTH{1'b0}}, w_xfer};
  assign w_ovf   = w_sum[COUNTER_WIDTH];
  assign w_unsol = credit_valid & (r_state != WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_balance <= INIT_BAL;
      r_error   <= 1'b0;
      r_borrow  <= 1'b0;
      r_retry   <= '0;
    end else begin
      r_balance <= w_ovf ? '1 : w_sum[COUNTER_WIDTH-1:0];
      if (w_ovf | w_unsol) r_error <= 1'b1;
      r_borrow <= 1'b0;
      case (r_state)
        IDLE: begin
          if ({1'b0, r_balance} <= LOW_WM) begin
            r_state  <= REQ;
            r_borrow <= 1'b1;
          end
        end
        REQ: r_state <= WAIT;
        WAIT: begin
          if (credit_valid) begin
            if (credit != '0) begin
              r_state <= IDLE;
            end else begin
              r_retry <= RETRY_LOAD;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (r_retry == '0) r_state <= IDLE;
          else               r_retry <= r_retry - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign borrow  = r_borrow;
  assign balance = r_balance;
  assign error   = r_error;

endmodule

// File: tb/tb_credit_debtor.sv
// Directed bench for credit_debtor: request/grant flow, zero-grant holdoff,
// unsolicited credit, saturation and reset behaviour, using three parameterisations.
module tb_credit_debtor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] in_data;

  // main instance: defaults (INITIAL_CREDIT 0, LOW_WATERMARK 4, RETRY_CYCLES 16)
  logic       m_rst, m_in_valid, m_out_ready, m_cv;
  logic [7:0] m_credit;
  logic       m_in_ready, m_out_valid, m_borrow, m_error;
  logic [15:0] m_out_data;
  logic [9:0] m_balance;

  // unsolicited-credit instance: starts at balance 20
  logic       u_rst, u_cv;
  logic [7:0] u_credit;
  logic       u_in_ready, u_out_valid, u_borrow, u_error;
  logic [15:0] u_out_data;
  logic [9:0] u_balance;

  // saturation instance: starts at 1020 and requests immediately
  logic       s_rst, s_cv;
  logic [7:0] s_credit;
  logic       s_in_ready, s_out_valid, s_borrow, s_error;
  logic [15:0] s_out_data;
  logic [9:0] s_balance;

  credit_debtor u_main (
    .clk(clk), .rst(m_rst), .in_data(in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready), .borrow(m_borrow),
    .credit(m_credit), .credit_valid(m_cv), .balance(m_balance), .error(m_error)
  );

  credit_debtor #(.INITIAL_CREDIT(20), .LOW_WATERMARK(4)) u_uns (
    .clk(clk), .rst(u_rst), .in_data(in_data), .in_valid(1'b0), .in_ready(u_in_ready),
    .out_data(u_out_data), .out_valid(u_out_valid), .out_ready(1'b0), .borrow(u_borrow),
    .credit(u_credit), .credit_valid(u_cv), .balance(u_balance), .error(u_error)
  );

  credit_debtor #(.INITIAL_CREDIT(1020), .LOW_WATERMARK(1020)) u_sat (
    .clk(clk), .rst(s_rst), .in_data(in_data), .in_valid(1'b0), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b0), .borrow(s_borrow),
    .credit(s_credit), .credit_valid(s_cv), .balance(s_balance), .error(s_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    m_rst = 1'b1; m_in_valid = 1'b1; m_out_ready = 1'b1; m_cv = 1'b0; m_credit = '0;
    u_rst = 1'b1; u_cv = 1'b0; u_credit = '0;
    s_rst = 1'b1; s_cv = 1'b0; s_credit = '0;
    in_data = 16'h0000;

    tick(); tick();
    settle();
    check("rst_balance",   32'(m_balance),   32'd0);
    check("rst_error",     32'(m_error),     32'd0);
    check("rst_borrow",    32'(m_borrow),    32'd0);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_in_ready",  32'(m_in_ready),  32'd0);

    // release reset: IDLE this cycle, REQ next
    m_rst = 1'b0;
    settle();
    check("c0_borrow", 32'(m_borrow), 32'd0);
    tick(); settle();
    check("c1_borrow",    32'(m_borrow),    32'd1);
    check("c1_out_valid", 32'(m_out_valid), 32'd0);
    tick();
    m_cv = 1'b1; m_credit = 8'd8;
    settle();
    check("c2_borrow", 32'(m_borrow), 32'd0);

    // eight back-to-back flits; balance hits 4 at k=4 so borrow pulses at k=5
    tick();
    m_cv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'hA500 + 16'(k);
      settle();
      check($sformatf("flit%0d_balance", k),   32'(m_balance),   32'(8 - k));
      check($sformatf("flit%0d_out_valid", k), 32'(m_out_valid), 32'd1);
      check($sformatf("flit%0d_out_data", k),  32'(m_out_data),  32'hA500 + 32'(k));
      check($sformatf("flit%0d_borrow", k),    32'(m_borrow),    (k == 5) ? 32'd1 : 32'd0);
      tick();
    end

    // empty in WAIT: zero grant starts holdoff
    m_cv = 1'b1; m_credit = 8'd0;
    settle();
    check("empty_out_valid", 32'(m_out_valid), 32'd0);
    check("empty_in_ready",  32'(m_in_ready),  32'd0);
    check("empty_balance",   32'(m_balance),   32'd0);
    tick();
    m_cv = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      settle();
      check($sformatf("hold%0d_borrow", k), 32'(m_borrow), 32'd0);
      tick();
    end
    settle();
    check("retry_borrow", 32'(m_borrow), 32'd1);
    check("retry_error",  32'(m_error),  32'd0);

    // WAIT: grant 10
    tick();
    m_cv = 1'b1; m_credit = 8'd10;
    settle();
    check("w2_borrow",  32'(m_borrow),  32'd0);
    check("w2_balance", 32'(m_balance), 32'd0);
    tick();
    m_cv = 1'b0;
    for (int k = 0; k < 7; k++) begin
      settle();
      check($sformatf("drain%0d_balance", k), 32'(m_balance), 32'(10 - k));
      check($sformatf("drain%0d_borrow", k),  32'(m_borrow),  32'd0);
      tick();
    end
    // REQ cycle with balance 3; pause the source so WAIT still sees 3
    m_in_valid = 1'b0;
    settle();
    check("req_balance", 32'(m_balance), 32'd3);
    check("req_borrow",  32'(m_borrow),  32'd1);
    tick();
    m_in_valid = 1'b1; m_cv = 1'b1; m_credit = 8'd8;
    settle();
    check("grant_xfer_balance",   32'(m_balance),   32'd3);
    check("grant_xfer_out_valid", 32'(m_out_valid), 32'd1);
    tick();
    m_cv = 1'b0;
    settle();
    check("net_balance", 32'(m_balance), 32'd10);
    check("net_error",   32'(m_error),   32'd0);

    // drain to 2 in WAIT, then reset with a grant that must be discarded
    repeat (8) tick();
    settle();
    check("wait2_balance", 32'(m_balance), 32'd2);
    check("wait2_borrow",  32'(m_borrow),  32'd0);
    m_rst = 1'b1; m_cv = 1'b1; m_credit = 8'd50;
    tick();
    m_rst = 1'b0; m_cv = 1'b0;
    settle();
    check("rst2_balance",   32'(m_balance),   32'd0);
    check("rst2_borrow",    32'(m_borrow),    32'd0);
    check("rst2_error",     32'(m_error),     32'd0);
    check("rst2_out_valid", 32'(m_out_valid), 32'd0);
    tick(); settle();
    check("rst2_reborrow", 32'(m_borrow), 32'd1);

    // unsolicited credit in IDLE
    u_rst = 1'b0;
    settle();
    check("uns_init_balance", 32'(u_balance), 32'd20);
    check("uns_init_error",   32'(u_error),   32'd0);
    u_cv = 1'b1; u_credit = 8'd5;
    tick();
    u_cv = 1'b0;
    settle();
    check("uns_balance", 32'(u_balance), 32'd25);
    check("uns_error",   32'(u_error),   32'd1);
    check("uns_borrow",  32'(u_borrow),  32'd0);
    tick(); tick(); settle();
    check("uns_sticky_error", 32'(u_error), 32'd1);
    u_rst = 1'b1;
    tick();
    u_rst = 1'b0;
    settle();
    check("uns_rst_error",   32'(u_error),   32'd0);
    check("uns_rst_balance", 32'(u_balance), 32'd20);

    // saturation: 1020 + 255 clamps to 1023
    s_rst = 1'b0;
    settle();
    check("sat_init_balance", 32'(s_balance), 32'd1020);
    check("sat_init_borrow",  32'(s_borrow),  32'd0);
    tick(); settle();
    check("sat_req_borrow", 32'(s_borrow), 32'd1);
    tick();
    s_cv = 1'b1; s_credit = 8'd255;
    settle();
    check("sat_wait_error", 32'(s_error), 32'd0);
    tick();
    s_cv = 1'b0;
    settle();
    check("sat_balance", 32'(s_balance), 32'd1023);
    check("sat_error",   32'(s_error),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
